// File: rtl/timer_sched_pkg.sv
// rtl/timer_sched_pkg.sv - shared types and timer register map for timer_job_scheduler
package timer_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_PL,
    WR_PH,
    WR_CTRL,
    WAIT,
    STOP,
    CLR,
    FIN
  } state_t;

  localparam logic [2:0] TMR_STATUS  = 3'd0;
  localparam logic [2:0] TMR_CONTROL = 3'd1;
  localparam logic [2:0] TMR_PERIODL = 3'd2;
  localparam logic [2:0] TMR_PERIODH = 3'd3;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  function automatic logic [15:0] ctrl_word(input logic ito, input logic cont,
                                            input logic start, input logic stop);
    ctrl_word             = '0;
    ctrl_word[CTRL_ITO]   = ito;
    ctrl_word[CTRL_CONT]  = cont;
    ctrl_word[CTRL_START] = start;
    ctrl_word[CTRL_STOP]  = stop;
  endfunction

endpackage

// File: rtl/timer_job_scheduler_rr_arbiter.sv
// rtl/timer_job_scheduler_rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    grant_idx,
  output logic             valid
);

  logic [IW-1:0] idx;

  // Scan from farthest to nearest so the candidate closest to ptr wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    idx       = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % N_REQ);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = idx;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_job_scheduler.sv
// rtl/timer_job_scheduler.sv - shares one interval timer between requesters as one-shot delays
module timer_job_scheduler
  import timer_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PW    = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*PW-1:0] req_period,
  input  logic [N_REQ-1:0]    cancel,
  output logic [N_REQ-1:0]    ack,
  output logic [N_REQ-1:0]    done,
  output logic                busy,
  output logic [2:0]          tmr_address,
  output logic                tmr_chipselect,
  output logic                tmr_write_n,
  output logic [15:0]         tmr_writedata,
  input  logic                tmr_irq
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t           state, next_state;
  logic [IW-1:0]    ptr, owner, arb_idx;
  logic [N_REQ-1:0] arb_grant;
  logic             arb_valid;
  logic [PW-1:0]    sel_period;
  logic [15:0]      period_hi;
  logic             done_pending;
  logic             take;

  logic [N_REQ-1:0] ack_d, done_d;
  logic             cs_d, wn_d;
  logic [2:0]       addr_d;
  logic [15:0]      wd_d;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req       (req),
    .ptr       (ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .valid     (arb_valid)
  );

  assign sel_period = req_period[int'(arb_idx)*PW +: PW];
  assign take       = (state == IDLE) && (next_state == WR_PL);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // A stale irq is flushed before any grant so it cannot end the next job early.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (tmr_irq) next_state = CLR;
               else if (arb_valid) next_state = WR_PL;
      WR_PL:   next_state = WR_PH;
      WR_PH:   next_state = WR_CTRL;
      WR_CTRL: next_state = WAIT;
      WAIT:    if (tmr_irq) next_state = CLR;
               else if (cancel[owner]) next_state = STOP;
      STOP:    next_state = CLR;
      CLR:     next_state = FIN;
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Bus outputs are computed for the state being entered, so they line up with it once registered.
  always_comb begin
    ack_d  = '0;
    done_d = '0;
    cs_d   = 1'b0;
    wn_d   = 1'b1;
    addr_d = TMR_STATUS;
    wd_d   = '0;
    case (next_state)
      WR_PL: begin
        ack_d  = arb_grant;
        cs_d   = 1'b1;
        wn_d   = 1'b0;
        addr_d = TMR_PERIODL;
        wd_d   = sel_period[15:0];
      end
      WR_PH: begin
        cs_d   = 1'b1;
        wn_d   = 1'b0;
        addr_d = TMR_PERIODH;
        wd_d   = period_hi;
      end
      WR_CTRL: begin
        cs_d   = 1'b1;
        wn_d   = 1'b0;
        addr_d = TMR_CONTROL;
        wd_d   = ctrl_word(1'b1, 1'b0, 1'b1, 1'b0);
      end
      STOP: begin
        cs_d   = 1'b1;
        wn_d   = 1'b0;
        addr_d = TMR_CONTROL;
        wd_d   = ctrl_word(1'b0, 1'b0, 1'b0, 1'b1);
      end
      CLR: begin
        cs_d   = 1'b1;
        wn_d   = 1'b0;
        addr_d = TMR_STATUS;
        wd_d   = '0;
      end
      FIN:     done_d = done_pending ? (N_REQ'(1) << owner) : '0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr          <= '0;
      owner        <= '0;
      period_hi    <= '0;
      done_pending <= 1'b0;
    end else begin
      if (take) begin
        owner     <= arb_idx;
        period_hi <= sel_period[31:16];
        ptr       <= (int'(arb_idx) == N_REQ - 1) ? '0 : arb_idx + 1'b1;
      end
      if (state == WAIT && next_state == CLR) done_pending <= 1'b1;
      else if (state == FIN)                  done_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack            <= '0;
      done           <= '0;
      busy           <= 1'b0;
      tmr_chipselect <= 1'b0;
      tmr_write_n    <= 1'b1;
      tmr_address    <= '0;
      tmr_writedata  <= '0;
    end else begin
      ack            <= ack_d;
      done           <= done_d;
      busy           <= (next_state != IDLE);
      tmr_chipselect <= cs_d;
      tmr_write_n    <= wn_d;
      tmr_address    <= addr_d;
      tmr_writedata  <= wd_d;
    end
  end

endmodule

// File: tb/tb_timer_job_scheduler.sv
// tb/tb_timer_job_scheduler.sv - directed table-driven bench with a behavioural interval timer
module tb_timer_job_scheduler;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   cancel = '0;
  logic [N*32-1:0] req_period = '0;
  logic [N-1:0]   ack, done;
  logic           busy;
  logic [2:0]     tmr_address;
  logic           tmr_chipselect, tmr_write_n;
  logic [15:0]    tmr_writedata;
  logic           tmr_irq;

  always #5 clk = ~clk;

  timer_job_scheduler #(.N_REQ(N), .PW(32)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req            (req),
    .req_period     (req_period),
    .cancel         (cancel),
    .ack            (ack),
    .done           (done),
    .busy           (busy),
    .tmr_address    (tmr_address),
    .tmr_chipselect (tmr_chipselect),
    .tmr_write_n    (tmr_write_n),
    .tmr_writedata  (tmr_writedata),
    .tmr_irq        (tmr_irq)
  );

  // Interval timer: one-shot counts period+1 cycles after START, TO sticky until status write.
  logic [15:0] t_pl, t_ph;
  logic        t_ito, t_cont, t_run, t_to;
  logic [31:0] t_cnt;
  logic        poke = 1'b0;
  logic        wr;
  assign wr      = tmr_chipselect && !tmr_write_n;
  assign tmr_irq = t_to && t_ito;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t_pl <= '0; t_ph <= '0; t_ito <= 1'b0; t_cont <= 1'b0;
      t_run <= 1'b0; t_to <= 1'b0; t_cnt <= '0;
    end else if (poke) begin
      t_to  <= 1'b1;
      t_ito <= 1'b1;
    end else if (wr) begin
      case (tmr_address)
        3'd0: t_to <= 1'b0;
        3'd1: begin
          t_ito  <= tmr_writedata[0];
          t_cont <= tmr_writedata[1];
          if (tmr_writedata[3]) t_run <= 1'b0;
          else if (tmr_writedata[2]) begin
            t_run <= 1'b1;
            t_cnt <= {t_ph, t_pl};
          end
        end
        3'd2: begin t_pl <= tmr_writedata; t_run <= 1'b0; end
        3'd3: begin t_ph <= tmr_writedata; t_run <= 1'b0; end
        default: ;
      endcase
    end else if (t_run) begin
      if (t_cnt == 0) begin
        t_to  <= 1'b1;
        t_cnt <= {t_ph, t_pl};
        if (!t_cont) t_run <= 1'b0;
      end else begin
        t_cnt <= t_cnt - 1;
      end
    end
  end

  typedef struct {
    logic [2:0]  a;
    logic [15:0] d;
    int          c;
  } wr_t;

  int   cyc = 0;
  wr_t  wq[$];
  int   ackq[$];
  int   doneq[$];
  int   donec[$];
  int   jobs_open = 0;
  bit   overlap = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr) wq.push_back('{tmr_address, tmr_writedata, cyc});
    for (int i = 0; i < N; i++) begin
      if (ack[i]) begin
        ackq.push_back(i);
        jobs_open = jobs_open + 1;
        if (jobs_open > 1) overlap = 1'b1;
      end
      if (done[i]) begin
        doneq.push_back(i);
        donec.push_back(cyc);
        jobs_open = jobs_open - 1;
      end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wq.delete(); ackq.delete(); doneq.delete(); donec.delete();
    jobs_open = 0;
    overlap   = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " ack"},   ack, 0);
    chk({tag, " done"},  done, 0);
    chk({tag, " busy"},  busy, 0);
    chk({tag, " cs"},    tmr_chipselect, 0);
    chk({tag, " wr_n"},  tmr_write_n, 1);
    chk({tag, " addr"},  tmr_address, 0);
    chk({tag, " wdata"}, tmr_writedata, 0);
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    req     = '0;
    cancel  = '0;
    step();
    step();
    check_reset_outputs(tag);
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 5000) begin step(); n++; end
    if (busy) chk({tag, " idle timeout"}, 1, 0);
  endtask

  // mode: 0 plain, 1 cancel cancel_at cycles after the START write, 2 cancel on irq, 3 stale irq first
  typedef struct {
    logic [3:0]  req;
    logic [31:0] period;
    int          mode;
    int          cancel_at;
    logic [3:0]  cmask;
    int          owner;
    logic [15:0] pl;
    logic [15:0] ph;
  } row_t;

  task automatic run_job(input row_t r, input string tag);
    int          n;
    bit          cxl;
    bit          found;
    int          ctrl_c;
    logic [2:0]  ea[$];
    logic [15:0] ed[$];
    clear_logs();
    cxl = (r.mode == 1) && r.cmask[r.owner];
    for (int i = 0; i < N; i++) req_period[i*32 +: 32] = r.period;
    if (r.mode == 3) begin
      poke = 1'b1;
      step();
      poke = 1'b0;
    end
    req = r.req;
    n = 0;
    while (ackq.size() == 0 && n < 200) begin step(); n++; end
    req = '0;
    chk({tag, " ack count"}, ackq.size(), 1);
    if (ackq.size() > 0) chk({tag, " ack owner"}, ackq[0], r.owner);
    if (r.mode == 1) begin
      found = 1'b0;
      n = 0;
      while (!found && n < 50) begin
        foreach (wq[i]) if (wq[i].a == 3'd1 && wq[i].d == 16'h0005) found = 1'b1;
        if (!found) begin step(); n++; end
      end
      if (!found) chk({tag, " start write timeout"}, 1, 0);
      repeat (r.cancel_at) step();
      cancel = r.cmask;
    end else if (r.mode == 2) begin
      n = 0;
      while (!tmr_irq && n < 2000) begin step(); n++; end
      if (!tmr_irq) chk({tag, " irq timeout"}, 1, 0);
      cancel = r.cmask;
    end
    wait_idle(tag);
    cancel = '0;
    step();
    step();

    if (r.mode == 3) begin ea.push_back(3'd0); ed.push_back(16'h0000); end
    ea.push_back(3'd2); ed.push_back(r.pl);
    ea.push_back(3'd3); ed.push_back(r.ph);
    ea.push_back(3'd1); ed.push_back(16'h0005);
    if (cxl) begin ea.push_back(3'd1); ed.push_back(16'h0008); end
    ea.push_back(3'd0); ed.push_back(16'h0000);

    chk({tag, " write count"}, wq.size(), ea.size());
    for (int i = 0; i < ea.size(); i++) begin
      if (i < wq.size()) begin
        chk($sformatf("%s wr%0d addr", tag, i), wq[i].a, ea[i]);
        chk($sformatf("%s wr%0d data", tag, i), wq[i].d, ed[i]);
      end
    end

    if (cxl) begin
      chk({tag, " done count"}, doneq.size(), 0);
    end else begin
      chk({tag, " done count"}, doneq.size(), 1);
      if (doneq.size() > 0) begin
        chk({tag, " done owner"}, doneq[0], r.owner);
        ctrl_c = -1;
        foreach (wq[i]) if (ctrl_c < 0 && wq[i].a == 3'd1 && wq[i].d == 16'h0005) ctrl_c = wq[i].c;
        chk({tag, " overhead"},
            longint'(donec[0]) - longint'(ctrl_c) - (longint'(r.period) + 1), 3);
      end
    end
  endtask

  row_t tbl[12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          n;
    int          exp_rr[7];
    row_t        r;

    tbl[0]  = '{4'b0001, 32'd10,         0, 0,  4'b0000, 0, 16'h000A, 16'h0000};
    tbl[1]  = '{4'b0001, 32'd0,          0, 0,  4'b0000, 0, 16'h0000, 16'h0000};
    tbl[2]  = '{4'b0110, 32'd5,          0, 0,  4'b0000, 1, 16'h0005, 16'h0000};
    tbl[3]  = '{4'b0110, 32'd2,          0, 0,  4'b0000, 2, 16'h0002, 16'h0000};
    tbl[4]  = '{4'b1001, 32'd7,          0, 0,  4'b0000, 3, 16'h0007, 16'h0000};
    tbl[5]  = '{4'b1001, 32'd1,          0, 0,  4'b0000, 0, 16'h0001, 16'h0000};
    tbl[6]  = '{4'b0100, 32'hFFFF_FFFF,  1, 50, 4'b0110, 2, 16'hFFFF, 16'hFFFF};
    tbl[7]  = '{4'b0100, 32'd1000,       1, 50, 4'b0110, 2, 16'h03E8, 16'h0000};
    tbl[8]  = '{4'b0010, 32'd6,          2, 0,  4'b0010, 1, 16'h0006, 16'h0000};
    tbl[9]  = '{4'b0001, 32'd3,          3, 0,  4'b0000, 0, 16'h0003, 16'h0000};
    tbl[10] = '{4'b1111, 32'd4,          0, 0,  4'b0000, 1, 16'h0004, 16'h0000};
    tbl[11] = '{4'b0001, 32'd20,         1, 5,  4'b1010, 0, 16'h0014, 16'h0000};

    do_reset("reset");
    for (int i = 0; i < 12; i++) run_job(tbl[i], $sformatf("row%0d", i));

    // Reset while the timer is running: nothing completes, next job starts clean.
    clear_logs();
    for (int i = 0; i < N; i++) req_period[i*32 +: 32] = 32'd100;
    req = 4'b0001;
    n = 0;
    while (ackq.size() == 0 && n < 50) begin step(); n++; end
    req = '0;
    chk("midjob ack", ackq.size(), 1);
    repeat (20) step();
    chk("midjob busy before reset", busy, 1);
    reset_n = 1'b0;
    step();
    check_reset_outputs("midjob");
    step();
    step();
    reset_n = 1'b1;
    repeat (150) step();
    chk("midjob done count", doneq.size(), 0);
    chk("midjob busy after", busy, 0);
    r = '{4'b0001, 32'h0001_0000, 1, 5, 4'b0001, 0, 16'h0000, 16'h0001};
    run_job(r, "after_reset");

    // Round-robin with all requesters held, then a narrowed request set.
    do_reset("rr reset");
    clear_logs();
    for (int i = 0; i < N; i++) req_period[i*32 +: 32] = 32'd3;
    req = 4'b1111;
    n = 0;
    while (ackq.size() < 6 && n < 500) begin step(); n++; end
    req = 4'b1010;
    n = 0;
    while (ackq.size() < 7 && n < 200) begin step(); n++; end
    req = '0;
    wait_idle("rr");
    step();
    exp_rr = '{0, 1, 2, 3, 0, 1, 3};
    chk("rr ack count", ackq.size(), 7);
    chk("rr done count", doneq.size(), 7);
    for (int i = 0; i < 7; i++) begin
      if (i < ackq.size())  chk($sformatf("rr ack%0d", i), ackq[i], exp_rr[i]);
      if (i < doneq.size()) chk($sformatf("rr done%0d", i), doneq[i], exp_rr[i]);
    end
    chk("rr overlap", overlap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
